local_port_fifo: RTL and testbench

LOCAL_PORT_FIFO -- requirements
Module: local_port_fifo

---
 rtl/local_port_fifo.sv | 85 ++++++++
 tb/tb_local_port_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/local_port_fifo.sv
// Local injection-port packet FIFO between an upstream injector and the router crossbar.
// Handshake-based write (one-cycle grant pulse) and grant-driven pop from the head slot.
module local_port_fifo #(
    parameter int unsigned dataWidth = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ReqUpStr,
    input  logic [dataWidth-1:0] PacketIn,
    output logic                 GntUpStr,
    output logic                 UpStrFull,
    output logic                 ReqDnStr,
    output logic [dataWidth-1:0] PacketOut,
    input  logic                 GntDnStr,
    input  logic                 DnStrFull,
    output logic [ADDR_W:0]      Occupancy
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [dataWidth-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 gnt_q, gnt_d;
    logic                 full_q, full_d;
    logic                 write_en;
    logic                 pop_en;

    // A live grant blocks a second write of the request still held during the upstream drop latency.
    assign write_en = ReqUpStr && !gnt_q && (count_q < DEPTH_C);
    assign pop_en   = GntDnStr && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gnt_d    = write_en;
        if (write_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (write_en && !pop_en) begin
            count_d = count_q + ONE_C;
        end else if (pop_en && !write_en) begin
            count_d = count_q - ONE_C;
        end
        full_d = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gnt_q    <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gnt_q    <= gnt_d;
            full_q   <= full_d;
        end
    end

    // Storage is not reset; count gating keeps stale words off PacketOut.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= PacketIn;
        end
    end

    assign GntUpStr  = gnt_q;
    assign UpStrFull = full_q;
    assign Occupancy = count_q;
    assign ReqDnStr  = (count_q != '0) && !DnStrFull;
    assign PacketOut = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_local_port_fifo.sv
// Self-checking bench for local_port_fifo: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_local_port_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ReqUpStr;
    logic [DW-1:0] PacketIn;
    logic          GntUpStr;
    logic          UpStrFull;
    logic          ReqDnStr;
    logic [DW-1:0] PacketOut;
    logic          GntDnStr;
    logic          DnStrFull;
    logic [AW:0]   Occupancy;

    local_port_fifo #(.dataWidth(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
        .GntUpStr(GntUpStr), .UpStrFull(UpStrFull),
        .ReqDnStr(ReqDnStr), .PacketOut(PacketOut),
        .GntDnStr(GntDnStr), .DnStrFull(DnStrFull),
        .Occupancy(Occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          gd;
        logic          df;
        logic          e_gnt;
        logic          e_full;
        logic          e_reqdn;
        logic [DW-1:0] e_out;
        logic [AW:0]   e_occ;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mq[$];
    logic          m_gnt;
    logic          m_full;

    function automatic vec_t mk(input logic req, input logic [DW-1:0] data, input logic gd,
                                input logic df, input logic e_gnt, input logic e_full,
                                input logic e_reqdn, input logic [DW-1:0] e_out, input int e_occ);
        vec_t v;
        v.req = req; v.data = data; v.gd = gd; v.df = df;
        v.e_gnt = e_gnt; v.e_full = e_full; v.e_reqdn = e_reqdn;
        v.e_out = e_out; v.e_occ = (AW+1)'(e_occ);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_gnt  = 1'b0;
        m_full = 1'b0;
    endtask

    // Drive one cycle of inputs, take the edge, advance the reference model.
    task automatic apply(input logic req, input logic [DW-1:0] d, input logic gd, input logic df);
        logic w, p;
        ReqUpStr = req; PacketIn = d; GntDnStr = gd; DnStrFull = df;
        w = req && !m_gnt && (mq.size() < DEPTH);
        p = gd && (mq.size() != 0);
        @(posedge clk); #1;
        if (p) void'(mq.pop_front());
        if (w) mq.push_back(d);
        m_gnt  = w;
        m_full = (mq.size() == DEPTH);
    endtask

    task automatic check_model(input string name);
        logic [DW-1:0] e_out;
        logic          e_reqdn;
        e_out   = (mq.size() != 0) ? mq[0] : '0;
        e_reqdn = (mq.size() != 0) && !DnStrFull;
        check(name, {GntUpStr, UpStrFull, ReqDnStr, PacketOut, Occupancy},
              {m_gnt, m_full, e_reqdn, e_out, (AW+1)'(mq.size())});
    endtask

    vec_t          tbl[13];
    logic [DW-1:0] popped[$];
    logic          rq;
    logic [DW-1:0] rd;

    initial begin
        reset = 1'b0; ReqUpStr = 1'b0; PacketIn = '0; GntDnStr = 1'b0; DnStrFull = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("reset_state", {GntUpStr, UpStrFull, ReqDnStr, PacketOut, Occupancy}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        apply(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_model("first_edge_idle");

        // single packet, held request, simultaneous push/pop, pop under DnStrFull, empty pop
        tbl[0]  = mk(1, 32'h9200_0401, 0, 0, 1, 0, 1, 32'h9200_0401, 1);
        tbl[1]  = mk(1, 32'h9200_0401, 0, 0, 0, 0, 1, 32'h9200_0401, 1);
        tbl[2]  = mk(0, 32'h0,         0, 0, 0, 0, 1, 32'h9200_0401, 1);
        tbl[3]  = mk(0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0);
        tbl[4]  = mk(0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0);
        tbl[5]  = mk(1, 32'hA1,        0, 0, 1, 0, 1, 32'hA1,        1);
        tbl[6]  = mk(0, 32'h0,         0, 0, 0, 0, 1, 32'hA1,        1);
        tbl[7]  = mk(1, 32'hB2,        0, 0, 1, 0, 1, 32'hA1,        2);
        tbl[8]  = mk(0, 32'h0,         0, 0, 0, 0, 1, 32'hA1,        2);
        tbl[9]  = mk(1, 32'hC3,        1, 0, 1, 0, 1, 32'hB2,        2);
        tbl[10] = mk(0, 32'h0,         0, 1, 0, 0, 0, 32'hB2,        2);
        tbl[11] = mk(0, 32'h0,         1, 1, 0, 0, 0, 32'hC3,        1);
        tbl[12] = mk(0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0);
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].req, tbl[i].data, tbl[i].gd, tbl[i].df);
            check($sformatf("table[%0d]", i),
                  {GntUpStr, UpStrFull, ReqDnStr, PacketOut, Occupancy},
                  {tbl[i].e_gnt, tbl[i].e_full, tbl[i].e_reqdn, tbl[i].e_out, tbl[i].e_occ});
        end

        // fill to DEPTH, then a blocked fifth request released by one pop
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, DW'(i), 1'b0, 1'b0);
            apply(1'b0, '0, 1'b0, 1'b0);
        end
        check("fill_full", {UpStrFull, Occupancy}, {1'b1, 3'd4});
        apply(1'b1, 32'd5, 1'b0, 1'b0);
        apply(1'b1, 32'd5, 1'b0, 1'b0);
        check("full_no_grant", {GntUpStr, Occupancy}, {1'b0, 3'd4});
        apply(1'b1, 32'd5, 1'b1, 1'b0);
        check("full_pop_no_write", {GntUpStr, UpStrFull, Occupancy, PacketOut}, {1'b0, 1'b0, 3'd3, 32'd2});
        apply(1'b1, 32'd5, 1'b0, 1'b0);
        check("grant_after_pop", {GntUpStr, UpStrFull, Occupancy}, {1'b1, 1'b1, 3'd4});
        apply(1'b0, '0, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("drain_head_%0d", i), PacketOut, DW'(i));
            apply(1'b0, '0, 1'b1, 1'b0);
        end
        check_model("drained");

        // ten packets with interleaved pops across pointer wrap
        popped.delete();
        for (int i = 1; i <= 10; i++) begin
            logic g1, g2;
            g1 = (i % 3) != 1;
            g2 = (i % 2) == 0;
            if (g1 && Occupancy != 0) popped.push_back(PacketOut);
            apply(1'b1, DW'(i), g1, 1'b0);
            check_model($sformatf("order_w%0d", i));
            if (g2 && Occupancy != 0) popped.push_back(PacketOut);
            apply(1'b0, '0, g2, 1'b0);
            check_model($sformatf("order_p%0d", i));
        end
        for (int k = 0; k < 12 && Occupancy != 0; k++) begin
            popped.push_back(PacketOut);
            apply(1'b0, '0, 1'b1, 1'b0);
        end
        check("order_count", 64'(popped.size()), 64'd10);
        for (int k = 0; k < popped.size(); k++)
            check($sformatf("order_pkt%0d", k), popped[k], DW'(k + 1));

        // randomized traffic against the reference model
        rq = 1'b0; rd = '0;
        for (int c = 0; c < 400; c++) begin
            if (GntUpStr) rq = 1'b0;
            else if (!rq) begin
                rq = 1'($urandom_range(0, 1));
                rd = $urandom;
            end
            apply(rq, rd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            check_model($sformatf("rand[%0d]", c));
        end

        // asynchronous reset with three packets stored
        for (int k = 0; k < 8 && Occupancy != 0; k++) apply(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h7000 + DW'(i), 1'b0, 1'b0);
            if (i < 2) apply(1'b0, '0, 1'b0, 1'b0);
        end
        check("pre_reset_occ", {GntUpStr, Occupancy}, {1'b1, 3'd3});
        ReqUpStr = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_reset", {GntUpStr, UpStrFull, ReqDnStr, PacketOut, Occupancy}, '0);
        model_reset();
        #1 reset = 1'b1;
        apply(1'b0, '0, 1'b1, 1'b0);
        check_model("post_reset_idle");
        apply(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("post_reset_write", {ReqDnStr, PacketOut, Occupancy}, {1'b1, 32'h1234_5678, 3'd1});
        apply(1'b0, '0, 1'b1, 1'b0);
        check_model("post_reset_pop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
